// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed seven-segment scan controller.
// Captures bus writes and commits them at frame boundaries.
// Scans one active-low anode per slot, with a blanking gap.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   seg7_cs    write strobe from the IO decoder
//   wdata      32-bit store data
//   an         digit anodes, active-low, bit i = digit i
//   seg        segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick one-cycle pulse after each frame commit
//
// Build option: define SEG7_LZ_BLANK_EN to suppress leading-zero digits.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seg7_cs,
   input  logic [31:0] wdata,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [31:0]   r_disp;
   logic [31:0]   r_pend_val;
   logic          r_pend_vld;
   logic          r_frame_tick;

   logic          w_wrap;
   logic          w_commit;
   logic          w_blank;
   logic          w_supp;
   logic [3:0]    w_nib;

   function automatic logic [7:0] f_hex(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign w_wrap   = (r_cnt == CW'(SCAN_DIV - 1));
   assign w_commit = w_wrap && (r_idx == 3'd7);
   assign w_blank  = (r_cnt < CW'(BLANK_CYCLES));
   assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
   // Digit i>=1 is dark when it and every higher nibble are zero.
   assign w_supp = (r_idx != 3'd0) &&
                   ((r_disp >> {r_idx, 2'b00}) == 32'd0);
`else
   assign w_supp = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_idx        <= 3'd0;
         r_disp       <= 32'd0;
         r_pend_val   <= 32'd0;
         r_pend_vld   <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_cnt        <= w_wrap ? '0 : r_cnt + CW'(1);
         r_frame_tick <= w_commit;
         if (w_wrap)
            r_idx <= r_idx + 3'd1;
         if (seg7_cs)
            r_pend_val <= wdata;
         if (w_commit) begin
            // A write landing on the commit edge beats the shadow.
            if (seg7_cs)
               r_disp <= wdata;
            else if (r_pend_vld)
               r_disp <= r_pend_val;
            r_pend_vld <= 1'b0;
         end else if (seg7_cs) begin
            r_pend_vld <= 1'b1;
         end
      end
   end

   always_comb begin
      an  = 8'hFF;
      seg = 8'hFF;
      if (!w_blank && !w_supp) begin
         an  = ~(8'b1 << r_idx);
         seg = f_hex(w_nib);
      end
   end

   assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display on the memory-mapped IO bus. Captures 32-bit words written to the seg7 address (0x10010020) through the IO decoder's `seg7_cs` strobe and `wdata`. Commits each word at a frame boundary so a digit never shows a torn value. Drives one active-low anode at a time with the hex glyph of the matching nibble, with an inter-digit blanking gap against ghosting.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `seg7_cs`  input  1  write strobe from the IO decoder; high for one store cycle.
- `wdata`  input  32  store data; sampled when `seg7_cs`=1.
- `an`  output  8  digit anodes, active-low; bit i is digit i, and digit 0 is the least-significant nibble.
- `seg`  output  8  segments, active-low; `seg[7]`=dp, always 1; `seg[6:0]`={g,f,e,d,c,b,a}.
- `frame_tick`  output  1  one-cycle pulse in the cycle after each frame commit edge.

## Operation
- State:
  - `cnt`: slot counter, 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - `idx`: 3-bit digit index.
  - `disp`: 32-bit displayed word.
  - `pend_val` (32 bits) and `pend_vld`: shadow of the last write.
  - `frame_tick` register.
- Counting:
  - `cnt` increments every cycle and wraps SCAN_DIV-1 → 0.
  - On each wrap, `idx` increments modulo 8, so 7 → 0 is a natural wrap.
- Write: when `seg7_cs`=1, `pend_val`<=`wdata` and `pend_vld`<=1. Later writes overwrite earlier ones; the last write before the commit wins.
- Commit edge: the clock edge where `idx`=7 and `cnt`=SCAN_DIV-1.
  - If `seg7_cs`=1 on that edge, `disp`<=`wdata`. Otherwise, if `pend_vld`=1, `disp`<=`pend_val`.
  - `pend_vld`<=0 in either case.
  - `frame_tick`<=1; it is 0 on every other edge.
- Outputs are combinational from registers only:
  - Blank phase (`cnt` < BLANK_CYCLES), or the digit is suppressed (see Configuration): `an`=8'hFF, `seg`=8'hFF.
  - Otherwise: `an`=~(8'b1<<`idx`), and `seg`={1'b1, hex(`disp`[4*idx+3:4*idx])}.
- Hex table, as `seg`:
  - 0..7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8..F: 80, 90, 88, 83, C6, A1, 86, 8E.
- `wdata` is never shown directly; a value is visible only after a commit.

## Timing
- Reset (`rst` sampled high): `cnt`=0, `idx`=0, `disp`=0, `pend_val`=0, `pend_vld`=0, `frame_tick`=0. As a result `an`=8'hFF and `seg`=8'hFF.
- Reset mid-frame aborts the slot and discards any pending write. There is no commit and no `frame_tick`.
- Slot timing:
  - After reset, digit 0 is lit starting with the cycle where `cnt`=BLANK_CYCLES.
  - Each digit is lit for SCAN_DIV−BLANK_CYCLES cycles per slot.
  - Frame period is 8·SCAN_DIV cycles, and `frame_tick` pulses exactly once per frame.
- Latency from write to display: the write is visible from the first lit cycle of slot 0 after the next commit edge. That is at most 8·SCAN_DIV+BLANK_CYCLES cycles.
- Holding `seg7_cs` high for multiple cycles behaves as back-to-back writes; the last one wins.

## Configuration
- `SEG7_LZ_BLANK_EN` (leading-zero blanking):
  - Defined: digit i≥1 is suppressed (`an` bit high, `seg`=8'hFF for that slot) when `disp`[31:4*i]==0. Digit 0 is never suppressed, so `disp`=0 shows a single "0".
  - Undefined: all 8 digits are always lit outside the blank phase.
  - Slot timing and `frame_tick` are identical in both builds.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYCLES=1.
- Reset → `an`=FF, `seg`=FF, `frame_tick`=0. At `cnt`=1 of slot 0: `an`=FE, `seg`=C0. The first `frame_tick` comes 32 cycles after reset release, then one every 32 cycles.
- Write 0x12345678 in slot 3:
  - Slots 4–7 still show 0 (`seg`=C0).
  - After the `frame_tick`: digit 0 shows `an`=FE, `seg`=80; digit 7 shows `an`=7F, `seg`=F9.
- Write 0xAAAAAAAA in slot 2, then 0x0000000F on the commit edge itself → the next frame shows digit 0 `seg`=8E, and digits 1–7 C0 (without `SEG7_LZ_BLANK_EN`).
- `SEG7_LZ_BLANK_EN` defined:
  - Write 0x000000A0 → digit 0 `seg`=C0, digit 1 `seg`=88, and `an` stays FF during slots 2–7.
  - Write 0 → only digit 0 lit, `seg`=C0.
- Write 0xDEADBEEF, then assert `rst` for 1 cycle in slot 5 before the commit → `an`=FF next cycle, `idx`=0, and the following frame displays 0 (the write is dropped).
- Blank phase: in every slot, the `cnt`=0 cycle has `an`=FF and `seg`=FF, and at most one `an` bit is ever low.
